// File: rtl/meta_pkg.sv
// Shared types and constants for the BSR metadata writer.
//   state_e : one-hot encoder FSM states
//   cfg_t   : configuration latched when a run starts
//   word_addr(): byte address of a 32-bit array element, base + (idx << ADDR_SHIFT)
package meta_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned ADDR_SHIFT = $clog2(WORD_BYTES);
  localparam int unsigned ADDR_WIDTH = 32;

  typedef enum logic [5:0] {
    ST_IDLE   = 6'b000001,
    ST_WR_RP0 = 6'b000010,
    ST_ACCEPT = 6'b000100,
    ST_WR_COL = 6'b001000,
    ST_WR_RP  = 6'b010000,
    ST_DONE   = 6'b100000
  } state_e;

  // Counts are zero-extended to 32 bits so the struct does not depend on CNT_WIDTH.
  typedef struct packed {
    logic [31:0]           rows;
    logic [31:0]           cols;
    logic [ADDR_WIDTH-1:0] rowptr_base;
    logic [ADDR_WIDTH-1:0] colidx_base;
  } cfg_t;

  // Array element address; wraps modulo 2^32 by construction.
  function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [ADDR_WIDTH-1:0] base,
                                                      input logic [31:0]           idx);
    return base + ADDR_WIDTH'(idx << ADDR_SHIFT);
  endfunction

endpackage

// File: rtl/meta_wr_port.sv
// Single-outstanding memory write register.
//   load_i          : request a new write (taken when idle or as the current one retires)
//   addr_i / data_i : payload for the new write
//   wr_ready_i      : memory accepts the current write
//   wr_valid_o, wr_addr_o, wr_data_o : registered write request, held while stalled
//   accept_c        : current write retires this cycle (valid && ready)
module meta_wr_port
  import meta_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  wr_ready_i,
  output logic                  wr_valid_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic                  accept_c
);

  logic                  valid_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;

  assign accept_c = valid_q & wr_ready_i;

  // Payload only changes when no write is pending, so a stalled request stays stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else if (load_i && (!valid_q || accept_c)) begin
      valid_q <= 1'b1;
      addr_q  <= addr_i;
      data_q  <= data_i;
    end else if (accept_c) begin
      valid_q <= 1'b0;
    end
  end

  assign wr_valid_o = valid_q;
  assign wr_addr_o  = addr_q;
  assign wr_data_o  = data_q;

endmodule

// File: rtl/bsr_meta_encoder.sv
// BSR metadata encoder: turns a row-major stream of per-block nonzero flags
// into the row_ptr and col_idx arrays, written one word at a time.
//   start, cfg_*            : run request and configuration (latched on start)
//   in_valid/in_nz/in_ready : flag stream
//   mem_wr_*                : single-word write port, valid/ready
//   busy, done, nnz_count, err : status
// Optional build macro META_OVERFLOW_CHECK_EN: suppress col_idx writes beyond
// MAX_NNZ entries and flag err (row pointers still carry the true count).
module bsr_meta_encoder
  import meta_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned MAX_NNZ    = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  cfg_rows,
  input  logic [CNT_WIDTH-1:0]  cfg_cols,
  input  logic [31:0]           cfg_rowptr_base,
  input  logic [31:0]           cfg_colidx_base,
  input  logic                  in_valid,
  input  logic                  in_nz,
  output logic                  in_ready,
  output logic                  mem_wr_valid,
  output logic [31:0]           mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic                  mem_wr_ready,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           nnz_count,
  output logic                  err
);

  (* fsm_encoding = "one_hot" *) state_e state_q;
  state_e state_d;

  cfg_t                  cfg_q, cfg_d;
  logic [CNT_WIDTH-1:0]  row_q, row_d;
  logic [CNT_WIDTH-1:0]  col_q, col_d;
  logic [31:0]           nnz_q, nnz_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  ld;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  wr_accept;

  logic                  in_fire;
  logic                  last_col;
  logic                  last_row;
  logic                  ovf_c;
  logic [31:0]           row_ptr_idx;

  assign in_fire     = in_valid && (state_q == ST_ACCEPT);
  assign last_col    = (32'(col_q) == (cfg_q.cols - 32'd1));
  assign last_row    = (32'(row_q) == (cfg_q.rows - 32'd1));
  assign row_ptr_idx = 32'(row_q) + 32'd1;

  // Capacity check: true when the next nonzero block has no col_idx slot left.
`ifdef META_OVERFLOW_CHECK_EN
  assign ovf_c = (nnz_q >= 32'(MAX_NNZ));
`else
  assign ovf_c = 1'b0 & (32'(MAX_NNZ) == 32'd0);
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (cfg_cols == '0) ? ST_DONE : ST_WR_RP0;
        end
      end
      ST_WR_RP0: begin
        if (wr_accept) begin
          state_d = (cfg_q.rows == 32'd0) ? ST_DONE : ST_ACCEPT;
        end
      end
      ST_ACCEPT: begin
        if (in_fire) begin
          if (in_nz && !ovf_c) begin
            state_d = ST_WR_COL;
          end else if (last_col) begin
            state_d = ST_WR_RP;
          end
        end
      end
      ST_WR_COL: begin
        if (wr_accept) begin
          state_d = last_col ? ST_WR_RP : ST_ACCEPT;
        end
      end
      ST_WR_RP: begin
        if (wr_accept) begin
          state_d = last_row ? ST_DONE : ST_ACCEPT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output and datapath next values; writes are launched together with the transition.
  always_comb begin
    cfg_d   = cfg_q;
    row_d   = row_q;
    col_d   = col_q;
    nnz_d   = nnz_q;
    err_d   = err_q;
    ld      = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    busy_d  = (state_d == ST_WR_RP0) || (state_d == ST_ACCEPT) ||
              (state_d == ST_WR_COL) || (state_d == ST_WR_RP);
    done_d  = (state_d == ST_DONE);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cfg_d.rows        = 32'(cfg_rows);
          cfg_d.cols        = 32'(cfg_cols);
          cfg_d.rowptr_base = cfg_rowptr_base;
          cfg_d.colidx_base = cfg_colidx_base;
          row_d             = '0;
          col_d             = '0;
          nnz_d             = '0;
          err_d             = (cfg_cols == '0);
          if (cfg_cols != '0) begin
            ld      = 1'b1;
            ld_addr = cfg_rowptr_base;
            ld_data = '0;
          end
        end
      end
      ST_ACCEPT: begin
        if (in_fire) begin
          if (in_nz) begin
            nnz_d = nnz_q + 32'd1;
            if (ovf_c) begin
              err_d = 1'b1;
            end else begin
              ld      = 1'b1;
              ld_addr = word_addr(cfg_q.colidx_base, nnz_q);
              ld_data = DATA_WIDTH'(col_q);
            end
          end
          // No col_idx write pending: advance directly, closing the row if needed.
          if (!in_nz || ovf_c) begin
            if (last_col) begin
              ld      = 1'b1;
              ld_addr = word_addr(cfg_q.rowptr_base, row_ptr_idx);
              ld_data = DATA_WIDTH'(nnz_d);
            end else begin
              col_d = col_q + CNT_WIDTH'(1);
            end
          end
        end
      end
      ST_WR_COL: begin
        if (wr_accept) begin
          if (last_col) begin
            ld      = 1'b1;
            ld_addr = word_addr(cfg_q.rowptr_base, row_ptr_idx);
            ld_data = DATA_WIDTH'(nnz_q);
          end else begin
            col_d = col_q + CNT_WIDTH'(1);
          end
        end
      end
      ST_WR_RP: begin
        if (wr_accept) begin
          col_d = '0;
          row_d = row_q + CNT_WIDTH'(1);
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q  <= '0;
      row_q  <= '0;
      col_q  <= '0;
      nnz_q  <= '0;
      err_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cfg_q  <= cfg_d;
      row_q  <= row_d;
      col_q  <= col_d;
      nnz_q  <= nnz_d;
      err_q  <= err_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  meta_wr_port #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_wr_port (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (ld),
    .addr_i     (ld_addr),
    .data_i     (ld_data),
    .wr_ready_i (mem_wr_ready),
    .wr_valid_o (mem_wr_valid),
    .wr_addr_o  (mem_wr_addr),
    .wr_data_o  (mem_wr_data),
    .accept_c   (wr_accept)
  );

  assign in_ready  = (state_q == ST_ACCEPT);
  assign busy      = busy_q;
  assign done      = done_q;
  assign nnz_count = nnz_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bsr_meta_encoder.sv
// Directed bench for bsr_meta_encoder with a write scoreboard.
module tb_bsr_meta_encoder;

`ifdef META_OVERFLOW_CHECK_EN
  localparam int unsigned TB_MAX_NNZ = 2;
`else
  localparam int unsigned TB_MAX_NNZ = 4096;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] cfg_rows;
  logic [15:0] cfg_cols;
  logic [31:0] cfg_rowptr_base;
  logic [31:0] cfg_colidx_base;
  logic        in_valid;
  logic        in_nz;
  logic        in_ready;
  logic        mem_wr_valid;
  logic [31:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic        mem_wr_ready = 1'b1;
  logic        busy;
  logic        done;
  logic [31:0] nnz_count;
  logic        err;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  int          wr_cnt = 0;
  int          rdy_mode = 0;
  int          cyc = 0;

  bsr_meta_encoder #(
    .DATA_WIDTH (32),
    .CNT_WIDTH  (16),
    .MAX_NNZ    (TB_MAX_NNZ)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .cfg_rows        (cfg_rows),
    .cfg_cols        (cfg_cols),
    .cfg_rowptr_base (cfg_rowptr_base),
    .cfg_colidx_base (cfg_colidx_base),
    .in_valid        (in_valid),
    .in_nz           (in_nz),
    .in_ready        (in_ready),
    .mem_wr_valid    (mem_wr_valid),
    .mem_wr_addr     (mem_wr_addr),
    .mem_wr_data     (mem_wr_data),
    .mem_wr_ready    (mem_wr_ready),
    .busy            (busy),
    .done            (done),
    .nnz_count       (nnz_count),
    .err             (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory ready: always 1, or 1 on one cycle out of three.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    mem_wr_ready = (rdy_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Every cycle a write is presented it must match the scoreboard head (covers stall stability).
  always @(negedge clk) begin
    if (rst_n && mem_wr_valid) begin
      chk("wr_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        chk("wr_addr", 64'(mem_wr_addr), 64'(exp_q[0][63:32]));
        chk("wr_data", 64'(mem_wr_data), 64'(exp_q[0][31:0]));
        if (mem_wr_ready) void'(exp_q.pop_front());
      end
      if (mem_wr_ready) wr_cnt++;
    end
  end

  // Reference model: pushes the expected write sequence, returns final nnz and err.
  task automatic model(input int rows, input int cols, input bit fl[$],
                       input logic [31:0] rpb, input logic [31:0] cib,
                       output int nnz, output bit e);
    int idx;
    nnz = 0;
    e   = 1'b0;
    idx = 0;
    if (cols == 0) begin
      e = 1'b1;
      return;
    end
    exp_q.push_back({rpb, 32'd0});
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        if (fl[idx]) begin
          nnz++;
          if (nnz <= int'(TB_MAX_NNZ)) exp_q.push_back({cib + 32'(4 * (nnz - 1)), 32'(c)});
          else e = 1'b1;
        end
        idx++;
      end
      exp_q.push_back({rpb + 32'(4 * (r + 1)), 32'(nnz)});
    end
  endtask

  task automatic do_start(input int rows, input int cols, input logic [31:0] rpb,
                          input logic [31:0] cib);
    @(posedge clk); #1;
    start           = 1'b1;
    cfg_rows        = 16'(rows);
    cfg_cols        = 16'(cols);
    cfg_rowptr_base = rpb;
    cfg_colidx_base = cib;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed(input bit fl[$]);
    bit got;
    foreach (fl[i]) begin
      in_valid = 1'b1;
      in_nz    = fl[i];
      got      = 1'b0;
      for (int k = 0; k < 300 && !got; k++) begin
        @(negedge clk);
        if (in_ready) got = 1'b1;
      end
      chk("flag_accepted", 64'(got), 64'd1);
      if (!got) break;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_nz    = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    if (seen) begin
      @(negedge clk);
      chk({tag, "_done_pulse"}, 64'(done), 64'd0);
      chk({tag, "_busy_idle"}, 64'(busy), 64'd0);
    end
  endtask

  task automatic run_case(input string tag, input int rows, input int cols, input bit fl[$],
                          input logic [31:0] rpb, input logic [31:0] cib, input int mode);
    int  enz;
    bit  eerr;
    rdy_mode = mode;
    model(rows, cols, fl, rpb, cib, enz, eerr);
    do_start(rows, cols, rpb, cib);
    if (cols != 0) begin
      @(negedge clk);
      chk({tag, "_busy"}, 64'(busy), 64'd1);
    end
    feed(fl);
    wait_done(tag);
    chk({tag, "_sb_drained"}, 64'(exp_q.size()), 64'd0);
    chk({tag, "_nnz"}, 64'(nnz_count), 64'(enz));
    chk({tag, "_err"}, 64'(err), 64'(eerr));
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bit fl[$];
    bit seen3;
    int vcnt;
    int dcnt;

    rst_n           = 1'b0;
    start           = 1'b0;
    cfg_rows        = '0;
    cfg_cols        = '0;
    cfg_rowptr_base = '0;
    cfg_colidx_base = '0;
    in_valid        = 1'b0;
    in_nz           = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_wr_valid", 64'(mem_wr_valid), 64'd0);
    chk("rst_wr_addr", 64'(mem_wr_addr), 64'd0);
    chk("rst_wr_data", 64'(mem_wr_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_nnz", 64'(nnz_count), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // R=2, C=3, flags 101/000, ready always high
    fl = '{1, 0, 1, 0, 0, 0};
    run_case("basic", 2, 3, fl, 32'h1000, 32'h2000, 0);

    // Same stimulus with ready high 1 cycle in 3
    run_case("stall", 2, 3, fl, 32'h1000, 32'h2000, 1);

    // Zero rows: only row_ptr[0]
    fl = {};
    run_case("rows0", 0, 4, fl, 32'h3000, 32'h4000, 0);

    // Zero columns: no writes, err
    run_case("cols0", 3, 0, fl, 32'h3000, 32'h4000, 0);

    // All-nonzero row; capacity limit only with the overflow check built in
    fl = '{1, 1, 1, 1};
    run_case("full", 1, 4, fl, 32'h0100, 32'h0200, 0);

    // Single column, flags 0,1,0
    fl = '{0, 1, 0};
    run_case("onecol", 3, 1, fl, 32'h0500, 32'h0600, 0);

    // Address wrap-around at the top of the address space
    fl = '{0, 1, 1};
    run_case("wrap", 1, 3, fl, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1);

    // Restart ignored while busy, then reset after the third write
    rdy_mode = 0;
    wr_cnt   = 0;
    begin
      int  enz;
      bit  eerr;
      fl = '{1, 1, 1, 1, 1, 1};
      model(2, 3, fl, 32'h3000, 32'h4000, enz, eerr);
    end
    do_start(2, 3, 32'h3000, 32'h4000);
    fl = '{1};
    feed(fl);
    @(posedge clk); #1;
    start           = 1'b1;
    cfg_rows        = 16'd5;
    cfg_rowptr_base = 32'h9000;
    cfg_colidx_base = 32'hA000;
    @(posedge clk); #1;
    start = 1'b0;
    feed(fl);
    seen3 = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (wr_cnt >= 3) begin
        seen3 = 1'b1;
        break;
      end
    end
    chk("restart_third_write", 64'(seen3), 64'd1);
    chk("restart_nnz", 64'(nnz_count), 64'd2);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_nnz", 64'(nnz_count), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    vcnt = 0;
    dcnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (mem_wr_valid) vcnt++;
      if (done) dcnt++;
    end
    chk("midrst_no_writes", 64'(vcnt), 64'd0);
    chk("midrst_no_done", 64'(dcnt), 64'd0);
    chk("midrst_write_total", 64'(wr_cnt), 64'd3);
    chk("midrst_busy_after", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
